wbs_slave_ctrl: RTL

Wishbone classic-cycle responder that sits directly behind the Caravel `wbs_*` port of `user_proj_example`. It decodes the fixed user-project address map into control/status registers and a shared 64-bit memory access port for the query, leaf, best and node SRAMs. It splits each 64-bit SRAM word into lower/upper 32-bit halves and returns single-cycle `wbs_ack_o` pulses at a fixed latency.

---
 rtl/wbs_pkg.sv | 30 +++
 rtl/wbs_slave_ctrl_if.sv | 21 ++
 rtl/wbs_addr_decode.sv | 32 +++
 rtl/wbs_slave_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wbs_pkg.sv
// rtl/wbs_pkg.sv - shared offsets, region and state enums for the Wishbone responder
package wbs_pkg;

    localparam logic [31:0] QUERY_OFS = 32'h0001_0000;
    localparam logic [31:0] LEAF_OFS  = 32'h0002_0000;
    localparam logic [31:0] BEST_OFS  = 32'h0003_0000;
    localparam logic [31:0] NODE_OFS  = 32'h0004_0000;

    localparam logic [15:0] REG_MODE  = 16'h0000;
    localparam logic [15:0] REG_DEBUG = 16'h0004;
    localparam logic [15:0] REG_DONE  = 16'h0008;
    localparam logic [15:0] REG_START = 16'h000C;
    localparam logic [15:0] REG_BUSY  = 16'h0010;

    typedef enum logic [2:0] {
        RGN_REG,
        RGN_QUERY,
        RGN_LEAF,
        RGN_BEST,
        RGN_NODE,
        RGN_NONE
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK
    } state_e;

endpackage

// File: rtl/wbs_slave_ctrl_if.sv
// rtl/wbs_slave_ctrl_if.sv - Wishbone classic bus bundle between Caravel master and the responder
interface wbs_slave_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wbs_addr_decode.sv
// rtl/wbs_addr_decode.sv - combinational address to region/index/half/register-offset decoder
module wbs_addr_decode
    import wbs_pkg::*;
#(
    parameter int          MEM_AW = 13,
    parameter logic [31:0] BASE   = 32'h3000_0000
) (
    input  logic [31:0]       adr_i,
    output region_e           region_o,
    output logic [MEM_AW-1:0] idx_o,
    output logic              half_o,
    output logic [15:0]       reg_off_o
);

    logic [31:0] page;
    assign page = adr_i & 32'hFFFF_0000;

    always_comb begin
        region_o = RGN_NONE;
        if (page == BASE)                  region_o = RGN_REG;
        else if (page == BASE + QUERY_OFS) region_o = RGN_QUERY;
        else if (page == BASE + LEAF_OFS)  region_o = RGN_LEAF;
        else if (page == BASE + BEST_OFS)  region_o = RGN_BEST;
        else if (page == BASE + NODE_OFS)  region_o = RGN_NODE;
    end

    // Node memory packs one node per 32-bit word; the others are 64-bit words.
    assign idx_o     = (region_o == RGN_NODE) ? MEM_AW'(adr_i[7:2]) : MEM_AW'(adr_i[15:3]);
    assign half_o    = adr_i[2];
    assign reg_off_o = adr_i[15:0];

endmodule

// File: rtl/wbs_slave_ctrl.sv
// rtl/wbs_slave_ctrl.sv - Wishbone responder for registers and SRAM halves; WBS_READBACK_EN enables QUERY/LEAF/NODE reads
module wbs_slave_ctrl
    import wbs_pkg::*;
#(
    parameter int          MEM_AW = 13,
    parameter int          NODE_W = 22,
    parameter logic [31:0] BASE   = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               rst_n,
    wbs_slave_ctrl_if.slave    wbs,
    output logic               mode_o,
    output logic               debug_o,
    output logic               fsm_start_o,
    input  logic               fsm_done_i,
    input  logic               fsm_busy_i,
    output logic [3:0]         mem_sel_o,
    output logic               mem_we_o,
    output logic [MEM_AW-1:0]  mem_addr_o,
    output logic [1:0]         mem_wmask_o,
    output logic [63:0]        mem_wdata_o,
    input  logic [63:0]        query_rdata_i,
    input  logic [63:0]        leaf_rdata_i,
    input  logic [63:0]        best_rdata_i,
    input  logic [NODE_W-1:0]  node_rdata_i
);

    state_e            state_q, state_d;
    region_e           region_q, region_d, dec_region;
    logic [MEM_AW-1:0] dec_idx, addr_q, addr_d;
    logic              dec_half, half_q, half_d;
    logic [15:0]       dec_off, off_q, off_d;
    logic              we_q, we_d, wr_q, wr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [3:0]        msel_q, msel_d;
    logic              mwe_q, mwe_d;
    logic [1:0]        wmask_q, wmask_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              mode_q, mode_d, debug_q, debug_d;
    logic              start_q, start_d, done_q, done_d, done_prev_q;
    logic              req_wr;

    wbs_addr_decode #(.MEM_AW(MEM_AW), .BASE(BASE)) u_dec (
        .adr_i     (wbs.wbs_adr_i),
        .region_o  (dec_region),
        .idx_o     (dec_idx),
        .half_o    (dec_half),
        .reg_off_o (dec_off)
    );

    assign req_wr = wbs.wbs_we_i && (wbs.wbs_sel_i != 4'b0000);

`ifdef WBS_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
    logic unused_rdata;
    assign unused_rdata = ^{query_rdata_i, leaf_rdata_i, node_rdata_i};
`endif

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        addr_d   = addr_q;
        half_d   = half_q;
        off_d    = off_q;
        we_d     = we_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        mode_d   = mode_q;
        debug_d  = debug_q;
        done_d   = done_q;
        msel_d   = 4'b0000;
        mwe_d    = 1'b0;
        wmask_d  = 2'b00;
        ack_d    = 1'b0;
        dat_d    = 32'h0;
        start_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                    state_d  = ST_ACCESS;
                    region_d = dec_region;
                    addr_d   = dec_idx;
                    half_d   = dec_half;
                    off_d    = dec_off;
                    we_d     = wbs.wbs_we_i;
                    wr_d     = req_wr;
                    wdata_d  = {wbs.wbs_dat_i, wbs.wbs_dat_i};
                    case (dec_region)
                        RGN_QUERY, RGN_LEAF: begin
                            if (req_wr || (!wbs.wbs_we_i && READBACK))
                                msel_d = (dec_region == RGN_QUERY) ? 4'b0001 : 4'b0010;
                            mwe_d   = req_wr;
                            wmask_d = req_wr ? (dec_half ? 2'b10 : 2'b01) : 2'b00;
                        end
                        RGN_BEST: if (!wbs.wbs_we_i) msel_d = 4'b0100;
                        RGN_NODE: begin
                            if (req_wr || (!wbs.wbs_we_i && READBACK)) msel_d = 4'b1000;
                            mwe_d   = req_wr;
                            wmask_d = req_wr ? 2'b11 : 2'b00;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ACCESS: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (wr_q && region_q == RGN_REG) begin
                        case (off_q)
                            REG_MODE:  mode_d  = wdata_q[0];
                            REG_DEBUG: debug_d = wdata_q[0];
                            REG_START: begin
                                start_d = 1'b1;
                                done_d  = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    if (!we_q) begin
                        case (region_q)
                            RGN_REG: begin
                                case (off_q)
                                    REG_MODE:  dat_d = {31'h0, mode_q};
                                    REG_DEBUG: dat_d = {31'h0, debug_q};
                                    REG_DONE:  dat_d = {31'h0, done_q};
                                    REG_BUSY:  dat_d = {31'h0, fsm_busy_i};
                                    default:   dat_d = 32'h0;
                                endcase
                            end
                            RGN_BEST: dat_d = half_q ? best_rdata_i[63:32] : best_rdata_i[31:0];
`ifdef WBS_READBACK_EN
                            RGN_QUERY: dat_d = half_q ? query_rdata_i[63:32] : query_rdata_i[31:0];
                            RGN_LEAF:  dat_d = half_q ? leaf_rdata_i[63:32] : leaf_rdata_i[31:0];
                            RGN_NODE:  dat_d = 32'(node_rdata_i);
`endif
                            default: dat_d = 32'h0;
                        endcase
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A done edge coinciding with a start write is kept rather than lost.
        if (fsm_done_i && !done_prev_q) done_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            region_q    <= RGN_NONE;
            addr_q      <= '0;
            half_q      <= 1'b0;
            off_q       <= 16'h0;
            we_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= 64'h0;
            msel_q      <= 4'b0000;
            mwe_q       <= 1'b0;
            wmask_q     <= 2'b00;
            ack_q       <= 1'b0;
            dat_q       <= 32'h0;
            mode_q      <= 1'b0;
            debug_q     <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            region_q    <= region_d;
            addr_q      <= addr_d;
            half_q      <= half_d;
            off_q       <= off_d;
            we_q        <= we_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            msel_q      <= msel_d;
            mwe_q       <= mwe_d;
            wmask_q     <= wmask_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            mode_q      <= mode_d;
            debug_q     <= debug_d;
            start_q     <= start_d;
            done_q      <= done_d;
            done_prev_q <= fsm_done_i;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign mode_o        = mode_q;
    assign debug_o       = debug_q;
    assign fsm_start_o   = start_q;
    assign mem_sel_o     = msel_q;
    assign mem_we_o      = mwe_q;
    assign mem_addr_o    = addr_q;
    assign mem_wmask_o   = wmask_q;
    assign mem_wdata_o   = wdata_q;

endmodule
